// File: rtl/minilab_pkg.sv
// rtl/minilab_pkg.sv - shared types and widths for the matrix fetch engine
package minilab_pkg;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    UNPACK = 3'd3,
    DONE   = 3'd4
  } fetch_state_t;

  localparam int MEM_DATA_W     = 64;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 8;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/fetch_unpack.sv
// rtl/fetch_unpack.sv - 64-bit word holder that hands out its bytes MSB-first
module fetch_unpack
  import minilab_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [MEM_DATA_W-1:0] load_data,
  input  logic                  advance,
  output logic [BYTE_W-1:0]     byte_out,
  output logic                  last_byte
);

  logic [MEM_DATA_W-1:0] data_q, data_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;

  // Next-state: a load restarts at the top byte, advance steps to the next byte, otherwise hold
  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    if (load) begin
      data_d = load_data;
      idx_d  = '0;
    end else if (advance) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Register the word and the byte index
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      idx_q  <= '0;
    end else begin
      data_q <= data_d;
      idx_q  <= idx_d;
    end
  end

  // Select the current byte, index 0 being bits 63:56
  always_comb begin
    byte_out  = data_q[(MEM_DATA_W-1) - BYTE_W*int'(idx_q) -: BYTE_W];
    last_byte = (idx_q == BYTE_IDX_W'(BYTES_PER_WORD-1));
  end

endmodule

// File: rtl/mem_fetch.sv
// rtl/mem_fetch.sv - fetches NUM_ROWS A words plus one B word and scatters their bytes into FIFOs; FETCH_PERF_EN adds a busy-cycle counter
module mem_fetch
  import minilab_pkg::*;
#(
  parameter int          NUM_ROWS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [31:0]           address,
  output logic                  read,
  input  logic                  waitrequest,
  input  logic [MEM_DATA_W-1:0] readdata,
  input  logic                  readdatavalid,
  input  logic [NUM_ROWS:0]     fifo_full,
  output logic [NUM_ROWS:0]     fifo_wren,
  output logic [BYTE_W-1:0]     fifo_wdata,
  output logic                  busy,
  output logic                  done
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]           fetch_cycles
`endif
);

  localparam int IDX_W = $clog2(NUM_ROWS + 1);

  fetch_state_t     state_q, state_d;
  logic [31:0]      address_q, address_d;
  logic             read_q, read_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;

  logic             load;
  logic             advance;
  logic [BYTE_W-1:0] byte_out;
  logic             last_byte;

  fetch_unpack u_unpack (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (readdata),
    .advance   (advance),
    .byte_out  (byte_out),
    .last_byte (last_byte)
  );

  // FIFO write strobe: only the current row, only while unpacking, never into a full FIFO
  always_comb begin
    fifo_wren = '0;
    for (int i = 0; i <= NUM_ROWS; i++) begin
      fifo_wren[i] = (state_q == UNPACK) && (word_idx_q == IDX_W'(i)) && !fifo_full[i];
    end
    fifo_wdata = (state_q == UNPACK) ? byte_out : '0;
  end

  // Sequencer next-state and registered-output values
  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    read_d     = read_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    word_idx_d = word_idx_q;
    load       = 1'b0;
    advance    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = REQ;
          read_d     = 1'b1;
          address_d  = BASE_ADDR;
          word_idx_d = '0;
          busy_d     = 1'b1;
        end
      end
      REQ: begin
        if (!waitrequest) begin
          state_d = WAIT;
          read_d  = 1'b0;
        end
      end
      WAIT: begin
        if (readdatavalid) begin
          load    = 1'b1;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        advance = |fifo_wren;
        if (advance && last_byte) begin
          if (word_idx_q == IDX_W'(NUM_ROWS)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
            address_d  = BASE_ADDR + 32'(word_idx_q) + 32'd1;
            read_d     = 1'b1;
            state_d    = REQ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state and output registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      address_q  <= '0;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      read_q     <= read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      word_idx_q <= word_idx_d;
    end
  end

  assign address = address_q;
  assign read    = read_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef FETCH_PERF_EN
  logic [15:0] cyc_q, cyc_d;

  // Busy-cycle counter: cleared by an accepted start, saturating, frozen once idle
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE && start) begin
      cyc_d = '0;
    end else if (busy_q && cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  // Register the busy-cycle count
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign fetch_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_mem_fetch.sv
// tb/tb_mem_fetch.sv - scoreboard bench for mem_fetch with a latency/stall memory model and FIFO back-pressure
module tb_mem_fetch;

  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   address;
  logic          read;
  logic          waitrequest;
  logic [63:0]   readdata;
  logic          readdatavalid;
  logic [NR:0]   fifo_full;
  logic [NR:0]   fifo_wren;
  logic [7:0]    fifo_wdata;
  logic          busy;
  logic          done;
`ifdef FETCH_PERF_EN
  logic [15:0]   fetch_cycles;
`endif

  always #5 clk = ~clk;

  mem_fetch #(.NUM_ROWS(NR), .BASE_ADDR(32'd0)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .address       (address),
    .read          (read),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .fifo_full     (fifo_full),
    .fifo_wren     (fifo_wren),
    .fifo_wdata    (fifo_wdata),
    .busy          (busy),
    .done          (done)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cycles  (fetch_cycles)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [63:0] mem [0:NR];
  logic [15:0] sb_q[$];
  logic [31:0] addr_q[$];
  int          cyc = 0;
  int          lat = 1;
  bit          stall_en = 0;
  bit          full_en = 0;
  int          stall_cnt = 0;
  int          stall_seen = 0;
  int          full_left = 0;
  bit          full_done = 0;
  bit          pend = 0;
  int          pend_cyc = 0;
  logic [31:0] pend_addr = 0;
  int          row_cnt [0:NR];
  int          done_cnt = 0;
  int          busy_cycles = 0;
  int          r0_first = -1;
  int          r0_last = -1;
  logic        prev_busy = 0;

  // Input driver: memory stall/return and FIFO back-pressure, updated just after each rising edge
  initial begin
    waitrequest   = 1'b0;
    readdatavalid = 1'b0;
    readdata      = '0;
    fifo_full     = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (stall_en && read && address == 32'd2 && stall_cnt < 5) begin
        waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        waitrequest = 1'b0;
      end
      if (pend && cyc == pend_cyc) begin
        readdatavalid = 1'b1;
        readdata      = mem[pend_addr];
        pend          = 0;
        for (int b = 0; b < 8; b++) begin
          sb_q.push_back({pend_addr[7:0], readdata[63-8*b -: 8]});
        end
      end else begin
        readdatavalid = 1'b0;
        readdata      = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      if (full_en && !full_done && row_cnt[3] == 2) begin
        full_left = 4;
        full_done = 1;
      end
      if (full_left > 0) begin
        fifo_full[3] = 1'b1;
        full_left--;
      end else begin
        fifo_full[3] = 1'b0;
      end
    end
  end

  // Monitor: sample outputs on the falling edge and check against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (read && !waitrequest) begin
          if (addr_q.size() == 0) chk("extra_read", 1, 0);
          else chk("address", address, addr_q.pop_front());
          pend      = 1;
          pend_cyc  = cyc + lat;
          pend_addr = address;
        end
        if (read && waitrequest) begin
          stall_seen++;
          chk("stall_addr", address, 32'd2);
          chk("stall_wren", fifo_wren, 0);
        end
        if (|fifo_wren) begin
          int row;
          row = 0;
          for (int i = 0; i <= NR; i++) if (fifo_wren[i]) row = i;
          chk("wren_onehot", $onehot(fifo_wren), 1);
          chk("wren_vs_full", fifo_wren & fifo_full, 0);
          row_cnt[row]++;
          if (sb_q.size() == 0) chk("extra_write", 1, 0);
          else chk("fifo_byte", {8'(row), fifo_wdata}, sb_q.pop_front());
          if (row == 0) begin
            if (r0_first < 0) r0_first = cyc;
            r0_last = cyc;
          end
        end
        if (done) begin
          done_cnt++;
          chk("busy_at_done", busy, 0);
          chk("busy_before_done", prev_busy, 1);
        end
        if (busy) busy_cycles++;
        prev_busy = busy;
      end
    end
  end

  task automatic check_reset();
    chk("rst_address", address, 0);
    chk("rst_read", read, 0);
    chk("rst_wren", fifo_wren, 0);
    chk("rst_wdata", fifo_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  task automatic prep(input int l, input bit s, input bit f);
    lat        = l;
    stall_en   = s;
    full_en    = f;
    stall_cnt  = 0;
    stall_seen = 0;
    full_done  = 0;
    full_left  = 0;
    done_cnt   = 0;
    busy_cycles = 0;
    r0_first   = -1;
    r0_last    = -1;
    pend       = 0;
    sb_q.delete();
    addr_q.delete();
    for (int i = 0; i <= NR; i++) begin
      row_cnt[i] = 0;
      addr_q.push_back(32'(i));
    end
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_seen", done_cnt != 0, 1);
    repeat (5) @(negedge clk);
    #1;
    chk("done_once", done_cnt, 1);
    chk("addr_drained", addr_q.size(), 0);
    chk("sb_drained", sb_q.size(), 0);
    for (int i = 0; i <= NR; i++) chk("row_bytes", row_cnt[i], 8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  // Main sequence
  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    mem[0] = 64'h0102030405060708;
    for (int i = 1; i <= NR; i++) mem[i] = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Word 0 known pattern, no stalls, bytes in 8 consecutive cycles
    prep(1, 0, 0);
    do_start();
    wait_done();
    chk("row0_consecutive", 32'(r0_last - r0_first), 7);

    // Read latency 3
    prep(3, 0, 0);
    do_start();
    wait_done();

    // Five-cycle waitrequest on word 2
    prep(2, 1, 0);
    do_start();
    wait_done();
    chk("stall_cycles", stall_seen, 5);

    // FIFO 3 full for four cycles after two bytes
    prep(1, 0, 1);
    do_start();
    wait_done();
    chk("full_applied", full_done, 1);

    // Reset during unpack of word 4, then a fresh fetch from address 0
    prep(1, 0, 0);
    do_start();
    n = 0;
    while (row_cnt[4] < 2 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reached_row4", row_cnt[4] >= 2, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    prep(1, 0, 0);
    do_start();
    wait_done();

    // Second start while busy is ignored
    prep(1, 0, 0);
    do_start();
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
`ifdef FETCH_PERF_EN
    chk("fetch_cycles", fetch_cycles, 64'(busy_cycles));
`endif
    repeat (10) @(negedge clk);
    chk("idle_after_done", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_fetch.md
MEM_FETCH -- requirements
Module: mem_fetch

Interface
REQ-001 Parameter NUM_ROWS, default 8: number of matrix-A rows, each with its own A FIFO.
REQ-002 Parameter BASE_ADDR, default 0: word address of A row 0; B vector at BASE_ADDR+NUM_ROWS.
REQ-003 Ports below are one per line: name  direction  width  meaning.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  single-cycle pulse starting a fetch of all NUM_ROWS+1 words.
REQ-007 address  output  32  memory word address.
REQ-008 read  output  1  memory read request.
REQ-009 waitrequest  input  1  memory stall; request not accepted while high.
REQ-010 readdata  input  64  returned word.
REQ-011 readdatavalid  input  1  readdata valid this cycle.
REQ-012 fifo_full  input  NUM_ROWS+1  per-FIFO full flag; bit NUM_ROWS is the B FIFO.
REQ-013 fifo_wren  output  NUM_ROWS+1  one-hot write enable.
REQ-014 fifo_wdata  output  8  byte shared by all FIFOs.
REQ-015 busy  output  1  high from accepted start until done.
REQ-016 done  output  1  one-cycle pulse after the last byte is written.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, UNPACK, DONE.
REQ-018 IDLE->REQ on start; start in any other state is ignored.
REQ-019 REQ: read=1, address=BASE_ADDR+word_idx; hold both steady while waitrequest=1; go to WAIT on the first cycle with waitrequest=0.
REQ-020 WAIT: read=0; capture readdata into the unpack register on readdatavalid, then go to UNPACK; wait with no timeout.
REQ-021 UNPACK: emit 8 bytes MSB-first (bits 63:56 first) to FIFO word_idx, at most one byte per cycle.
REQ-022 A byte is written only when fifo_full[word_idx]=0; while full, fifo_wren=0 and the byte index holds.
REQ-023 After the 8th byte: if word_idx==NUM_ROWS go to DONE, else increment word_idx and go to REQ.
REQ-024 DONE: done=1 for one cycle, then go to IDLE.
REQ-025 Exactly one outstanding read; a readdatavalid outside WAIT is ignored.
REQ-026 Best case per word: 1 REQ + ≥1 WAIT + 8 UNPACK cycles.
REQ-027 fifo_wren is never more than one-hot and is zero outside UNPACK.

Reset
REQ-028 rst wins over every other input, including mid-transaction.
REQ-029 Reset values: state=IDLE; address=0; read=0; fifo_wren=0; fifo_wdata=0; busy=0; done=0; word_idx=0; byte_idx=0.
REQ-030 After reset, data returned for an aborted read is discarded.

Configuration
REQ-031 With FETCH_PERF_EN defined: adds output fetch_cycles[15:0], which counts cycles while busy=1, clears on an accepted start, saturates at 16'hFFFF, holds after done, and resets to 0.
REQ-032 Without FETCH_PERF_EN: the port and the counter are absent; all other behaviour is identical.

Structure
REQ-033 Package minilab_pkg holds the fetch_state_t enum, MEM_DATA_W=64, BYTE_W=8 and BYTES_PER_WORD=8.
REQ-034 One sub-module, fetch_unpack: 64-bit load register plus 3-bit byte counter with advance/stall input, last-byte flag and byte output.

Verification
REQ-035 Memory word0=64'h0102030405060708, no stalls, start -> FIFO0 receives 01..08 in order; bytes written in exactly 8 consecutive cycles.
REQ-036 Full 9-word fetch with readdatavalid latency 3 -> each FIFO gets its 8 bytes; addresses 0..8 issued in order; done pulses once; busy falls in the same cycle.
REQ-037 waitrequest high 5 cycles on word 2 -> address=2 and read=1 held for all 5 cycles; no FIFO writes during the stall.
REQ-038 fifo_full[3] high for 4 cycles after 2 bytes of row 3 are written -> no writes for 4 cycles, then bytes 3..8 follow; no byte lost or duplicated.
REQ-039 rst asserted during UNPACK of word 4, then start -> all outputs at reset values for one cycle; the new fetch begins at address 0.
REQ-040 Second start while busy -> ignored; with FETCH_PERF_EN defined, fetch_cycles equals the busy-high cycle count of the first run.
